// File: rtl/reg_pipe_elastic_if.sv
// Handshake bundle for reg_pipe_elastic: producer side (I*), consumer side (O*) and occupancy.
// A word moves across either boundary only in a cycle where its valid and ready are both 1.
interface reg_pipe_elastic_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] I;
  logic             I_valid;
  logic             I_ready;
  logic [WIDTH-1:0] O;
  logic             O_valid;
  logic             O_ready;
  logic [CW-1:0]    COUNT;

  modport slave (
    input  I, I_valid, O_ready,
    output I_ready, O, O_valid, COUNT
  );

  modport master (
    output I, I_valid, O_ready,
    input  I_ready, O, O_valid, COUNT
  );
endinterface

// File: rtl/reg_pipe_elastic.sv
// DEPTH-stage elastic register pipeline with per-stage valid/ready, clock enable,
// synchronous reset to INIT, selectable active clock edge and a registered occupancy count.
module reg_pipe_elastic #(
  parameter int             WIDTH       = 4,
  parameter int             DEPTH       = 2,
  parameter logic [WIDTH-1:0] INIT      = '0,
  parameter bit             CLK_POSEDGE = 1'b1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CE,
  reg_pipe_elastic_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [CW-1:0]    r_count;

  logic             w_clk;
  logic [DEPTH-1:0] w_ready;
  logic             w_in_xfer;
  logic             w_out_xfer;

  assign w_clk = CLK_POSEDGE ? CLK : ~CLK;

  // A stage can load when it or any stage downstream of it has a hole, or the consumer drains.
  always_comb begin
    logic all_v;
    all_v   = 1'b1;
    w_ready = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      all_v      = all_v & r_valid[k];
      w_ready[k] = ~all_v | bus.O_ready;
    end
  end

  assign bus.I_ready = CE & w_ready[0];
  assign bus.O_valid = CE & r_valid[DEPTH-1];
  assign bus.O       = (|r_valid) ? r_data[DEPTH-1] : INIT;
  assign bus.COUNT   = r_count;

  assign w_in_xfer  = bus.I_valid & bus.I_ready;
  assign w_out_xfer = bus.O_valid & bus.O_ready;

  always_ff @(posedge w_clk) begin
    if (RESET) begin
      r_valid <= '0;
      r_count <= '0;
      for (int k = 0; k < DEPTH; k++) r_data[k] <= INIT;
    end else if (CE) begin
      if (w_ready[0]) begin
        r_valid[0] <= bus.I_valid;
        if (bus.I_valid) r_data[0] <= bus.I;
      end
      // Bubbles advance like words but never overwrite data, keeping O stable while invalid.
      for (int k = 1; k < DEPTH; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) r_data[k] <= r_data[k-1];
        end
      end
      if (w_in_xfer && !w_out_xfer) r_count <= r_count + 1'b1;
      else if (!w_in_xfer && w_out_xfer) r_count <= r_count - 1'b1;
    end
  end
endmodule
